// File: rtl/aes_pkg.sv
// AES definitions shared by the forward key expansion and the decryption key scheduler:
// S-box, RotWord, SubWord, Rcon, the scheduler state type and the round-key width.
package aes_pkg;

  localparam int AES_RK_W = 128;

  typedef enum logic [1:0] {IDLE, EXPAND, STREAM} ks_state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s;
    s = 8'h00;
    case (x)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Round constants for k = 1..10; anything else yields zero.
  function automatic logic [31:0] rcon(input logic [3:0] k);
    logic [7:0] rc;
    case (k)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

endpackage

// File: rtl/aes_dec_key_sched_if.sv
// Key-in and round-key-out handshakes of the decryption key scheduler.
interface aes_dec_key_sched_if #(parameter int NK = 4);
  import aes_pkg::*;

  logic                  key_valid;
  logic                  key_ready;
  logic [NK*32-1:0]      key;
  logic                  rk_valid;
  logic                  rk_ready;
  logic [AES_RK_W-1:0]   rk;
  logic [3:0]            rk_round;
  logic                  rk_last;

  modport master (
    output key_valid, key, rk_ready,
    input  key_ready, rk_valid, rk, rk_round, rk_last
  );

  modport slave (
    input  key_valid, key, rk_ready,
    output key_ready, rk_valid, rk, rk_round, rk_last
  );
endinterface

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on one 32-bit word.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word,
  output logic [31:0] sub
);
  assign sub = {sbox(word[31:24]), sbox(word[23:16]), sbox(word[15:8]), sbox(word[7:0])};
endmodule

// File: rtl/aes_dec_key_sched.sv
// Sequential AES decryption key scheduler: expands the cipher key one word per clock,
// then streams round keys NR down to 0.
module aes_dec_key_sched
  import aes_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                clk,
  input  logic                rst,
  aes_dec_key_sched_if.slave  bus
);

  localparam int NW = 4 * (NR + 1);
  localparam int IW = $clog2(NW);

  if (!((NK == 4 && NR == 10) || (NK == 6 && NR == 12) || (NK == 8 && NR == 14))) begin : g_bad_cfg
    $error("aes_dec_key_sched: illegal NK/NR pair");
  end

  ks_state_t     state, state_nxt;
  logic [31:0]   w [NW];
  logic [IW-1:0] i;
  logic [2:0]    pos;     // i mod NK, tracked incrementally
  logic [3:0]    rc_idx;  // i / NK, the Rcon index
  logic [3:0]    r;

  logic [IW-1:0] i_m1, i_mnk, rk_base;
  logic [31:0]   w_prev, w_back, sub_in, sub_out, temp;
  logic          last_word;

  assign i_m1      = i - IW'(1);
  assign i_mnk     = i - IW'(NK);
  assign rk_base   = IW'({r, 2'b00});
  assign last_word = (i == IW'(NW - 1));
  assign w_prev    = w[i_m1];
  assign w_back    = w[i_mnk];

  // One S-box instance serves both the Rcon step and the NK=8 mid-key step.
  assign sub_in = (pos == 3'd0) ? rot_word(w_prev) : w_prev;

  aes_sub_word u_sub_word (
    .word (sub_in),
    .sub  (sub_out)
  );

  always_comb begin
    if (pos == 3'd0)
      temp = sub_out ^ rcon(rc_idx);
    else if (NK > 6 && pos == 3'd4)
      temp = sub_out;
    else
      temp = w_prev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      i      <= '0;
      pos    <= '0;
      rc_idx <= '0;
      r      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.key_valid) begin
            i      <= IW'(NK);
            pos    <= '0;
            rc_idx <= 4'd1;
          end
        end
        EXPAND: begin
          i <= i + IW'(1);
          if (pos == 3'(NK - 1)) begin
            pos    <= '0;
            rc_idx <= rc_idx + 4'd1;
          end else begin
            pos <= pos + 3'd1;
          end
          if (last_word) r <= 4'(NR);
        end
        STREAM: begin
          if (bus.rk_ready && r != 4'd0) r <= r - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the word store carries no reset; its contents only matter after a key load,
  // and leaving it out keeps the array mappable to plain flops or RAM without a clear.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.key_valid) begin
      for (int j = 0; j < NK; j++) w[j] <= bus.key[(NK - j) * 32 - 1 -: 32];
    end else if (state == EXPAND) begin
      w[i] <= w_back ^ temp;
    end
  end

  // NOTE: every output and state_nxt gets a default first so no path infers a latch.
  always_comb begin
    state_nxt    = state;
    bus.key_ready = 1'b0;
    bus.rk_valid  = 1'b0;
    bus.rk        = '0;
    bus.rk_round  = '0;
    bus.rk_last   = 1'b0;
    case (state)
      IDLE: begin
        bus.key_ready = 1'b1;
        if (bus.key_valid) state_nxt = EXPAND;
      end
      EXPAND: begin
        if (last_word) state_nxt = STREAM;
      end
      STREAM: begin
        bus.rk_valid = 1'b1;
        bus.rk       = {w[rk_base], w[rk_base + IW'(1)], w[rk_base + IW'(2)], w[rk_base + IW'(3)]};
        bus.rk_round = r;
        bus.rk_last  = (r == 4'd0);
        if (bus.rk_ready && r == 4'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Directed bench for aes_dec_key_sched with AES-128/192/256 instances and FIPS-197 vectors.
module tb_aes_dec_key_sched;
  import aes_pkg::*;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KALT = 256'hdeadbeef0123456789abcdeffedcba9876543210a5a5a5a55a5a5a5a0f0f0f0f;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_dec_key_sched_if #(.NK(4)) if128 ();
  aes_dec_key_sched_if #(.NK(6)) if192 ();
  aes_dec_key_sched_if #(.NK(8)) if256 ();

  aes_dec_key_sched #(.NK(4), .NR(10)) dut128 (.clk(clk), .rst(rst), .bus(if128.slave));
  aes_dec_key_sched #(.NK(6), .NR(12)) dut192 (.clk(clk), .rst(rst), .bus(if192.slave));
  aes_dec_key_sched #(.NK(8), .NR(14)) dut256 (.clk(clk), .rst(rst), .bus(if256.slave));

  int           sel;
  logic         kv, rr;
  logic [255:0] key_drv;

  assign if128.key_valid = kv && (sel == 0);
  assign if192.key_valid = kv && (sel == 1);
  assign if256.key_valid = kv && (sel == 2);
  assign if128.key       = key_drv[255:128];
  assign if192.key       = key_drv[255:64];
  assign if256.key       = key_drv;
  assign if128.rk_ready  = rr;
  assign if192.rk_ready  = rr;
  assign if256.rk_ready  = rr;

  logic         o_key_ready, o_rk_valid, o_rk_last;
  logic [127:0] o_rk;
  logic [3:0]   o_round;

  always_comb begin
    case (sel)
      1: begin
        o_key_ready = if192.key_ready; o_rk_valid = if192.rk_valid; o_rk = if192.rk;
        o_round = if192.rk_round; o_rk_last = if192.rk_last;
      end
      2: begin
        o_key_ready = if256.key_ready; o_rk_valid = if256.rk_valid; o_rk = if256.rk;
        o_round = if256.rk_round; o_rk_last = if256.rk_last;
      end
      default: begin
        o_key_ready = if128.key_ready; o_rk_valid = if128.rk_valid; o_rk = if128.rk;
        o_round = if128.rk_round; o_rk_last = if128.rk_last;
      end
    endcase
  end

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_rk [15];
  bit           known  [15];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_ready"}, o_key_ready, 1);
    check({tag, "_rk_valid"}, o_rk_valid, 0);
    check({tag, "_rk"}, o_rk, 0);
    check({tag, "_rk_round"}, o_round, 0);
    check({tag, "_rk_last"}, o_rk_last, 0);
  endtask

  task automatic clear_expected();
    for (int k = 0; k < 15; k++) begin
      exp_rk[k] = '0;
      known[k]  = 1'b0;
    end
  endtask

  task automatic load_128();
    clear_expected();
    exp_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    exp_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int k = 0; k <= 10; k++) known[k] = 1'b1;
  endtask

  task automatic load_192();
    clear_expected();
    exp_rk[0]  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    exp_rk[1]  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    exp_rk[2]  = 128'hec12068e6c827f6b0e7a95b95c56fec2;
    exp_rk[3]  = 128'h4db7b4bd69b5411885a74796e92538fd;
    exp_rk[4]  = 128'he75fad44bb095386485af05721efb14f;
    exp_rk[5]  = 128'ha448f6d94d6dce24aa326360113b30e6;
    exp_rk[6]  = 128'ha25e7ed583b1cf9a27f939436a94f767;
    exp_rk[7]  = 128'hc0a69407d19da4e1ec1786eb6fa64971;
    exp_rk[8]  = 128'h485f703222cb8755e26d135233f0b7b3;
    exp_rk[9]  = 128'h40beeb282f18a2596747d26b458c553e;
    exp_rk[10] = 128'ha7e1466c9411f1df821f750aad07d753;
    exp_rk[11] = 128'hca4005388fcc5006282d166abc3ce7b5;
    exp_rk[12] = 128'he98ba06f448c773c8ecc720401002202;
    for (int k = 0; k <= 12; k++) known[k] = 1'b1;
  endtask

  task automatic load_256();
    clear_expected();
    exp_rk[0]  = K256[255:128];
    exp_rk[14] = 128'hfe4890d1e6188d0b046df344706c631e;
    known[0]  = 1'b1;
    known[14] = 1'b1;
  endtask

  // Called at a negedge; the key is accepted on the following posedge.
  task automatic send_key(input logic [255:0] k);
    int n = 0;
    while (!o_key_ready && n < 100) begin
      tick();
      n++;
    end
    check("key_ready_before_accept", o_key_ready, 1);
    key_drv = k;
    kv      = 1'b1;
    tick();
    kv      = 1'b0;
  endtask

  task automatic wait_valid(input int lat, input bit busy, input logic [255:0] other);
    int n = 0;
    bit saw_ready = 1'b0;
    bit saw_out   = 1'b0;
    if (busy) begin
      key_drv = other;
      kv      = 1'b1;
    end
    while (!o_rk_valid && n < 200) begin
      if (o_key_ready) saw_ready = 1'b1;
      if (o_rk != '0 || o_round != '0 || o_rk_last) saw_out = 1'b1;
      tick();
      n++;
    end
    check("latency", n, lat);
    check("key_ready_low_in_expand", saw_ready, 0);
    check("outputs_zero_in_expand", saw_out, 0);
  endtask

  // mode 0: rk_ready held high; mode 1: 5-clock stall at round 7, then random.
  // Returns early with round stop_at on the bus (not yet transferred) when stop_at >= 0.
  task automatic run_stream(input int nr, input int mode, input int stop_at);
    int           r = nr;
    int           n = 0;
    int           stall = 0;
    bit           prev_stalled = 1'b0;
    logic [127:0] prev_rk = '0;
    logic [3:0]   prev_round = '0;
    rr = 1'b1;
    while (r >= 0 && n < 300) begin
      if (!o_rk_valid) begin
        check("rk_valid_in_stream", o_rk_valid, 1);
        break;
      end
      if (r == stop_at) return;
      if (prev_stalled) begin
        check("stall_rk_stable", o_rk, prev_rk);
        check("stall_round_stable", o_round, prev_round);
      end
      check("rk_round", o_round, r);
      if (mode == 1) begin
        if (r > 7) rr = 1'b1;
        else if (r == 7 && stall < 5) begin
          rr = 1'b0;
          stall++;
        end else rr = 1'($urandom_range(0, 1));
      end else begin
        rr = 1'b1;
      end
      if (rr) begin
        if (known[r]) check($sformatf("rk_r%0d", r), o_rk, exp_rk[r]);
        check("rk_last", o_rk_last, (r == 0));
        check("key_ready_low_in_stream", o_key_ready, 0);
        r--;
      end
      prev_stalled = !rr;
      prev_rk      = o_rk;
      prev_round   = o_round;
      tick();
      n++;
    end
    rr = 1'b1;
    check("stream_complete", (r < 0), 1);
    check("key_ready_after_last", o_key_ready, 1);
    check("rk_valid_after_last", o_rk_valid, 0);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    kv      = 1'b0;
    rr      = 1'b1;
    sel     = 0;
    key_drv = '0;
    @(negedge clk);
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // AES-128, rk_ready held high
    sel = 0;
    load_128();
    send_key(K128);
    wait_valid(40, 1'b0, '0);
    run_stream(10, 0, -1);

    // AES-256
    sel = 2;
    load_256();
    send_key(K256);
    wait_valid(52, 1'b0, '0);
    run_stream(14, 0, -1);

    // AES-192, all round keys
    sel = 1;
    load_192();
    send_key(K192);
    wait_valid(46, 1'b0, '0);
    run_stream(12, 0, -1);

    // Backpressure on AES-128
    sel = 0;
    load_128();
    send_key(K128);
    wait_valid(40, 1'b0, '0);
    run_stream(10, 1, -1);

    // Key offered while busy through expansion and streaming of AES-192
    sel = 1;
    load_192();
    send_key(K192);
    wait_valid(46, 1'b1, KALT);
    run_stream(12, 0, -1);
    kv = 1'b0;
    tick();
    check("busy_key_not_queued", o_key_ready, 1);

    // Reset at expansion word 20, then a clean run
    sel = 0;
    load_128();
    send_key(K128);
    for (int k = 0; k < 16; k++) tick();
    pulse_reset("rst_expand");
    send_key(K128);
    wait_valid(40, 1'b0, '0);
    run_stream(10, 0, -1);

    // Reset at the round-4 transfer, then a clean run
    send_key(K128);
    wait_valid(40, 1'b0, '0);
    run_stream(10, 0, 4);
    check("round4_visible", o_round, 4);
    pulse_reset("rst_stream");
    send_key(K128);
    wait_valid(40, 1'b0, '0);
    run_stream(10, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule

// File: doc/aes_dec_key_sched.md
# aes_dec_key_sched

Sequential AES decryption key scheduler. It accepts a cipher key over a valid/ready handshake and expands it internally, one 32-bit word per clock. It then streams the round keys out in reverse order, round NR first and round 0 last, over a second valid/ready handshake. It feeds the inverse-cipher datapath, which consumes one round key per round, and shares its S-box, RotWord and Rcon definitions with the forward key expansion.

## Interface
- NK, 4, key length in 32-bit words; legal values are 4, 6, 8.
- NR, 10, number of rounds; legal values are 10, 12, 14, paired with NK = 4, 6, 8.
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- key_valid  in  1  the cipher key on `key` is offered.
- key_ready  out  1  the block is idle and can accept a key.
- key  in  NK*32  cipher key; word 0 is in the MSBs `[NK*32-1 -: 32]`.
- rk_valid  out  1  `rk` holds a valid round key.
- rk_ready  in  1  the consumer accepts `rk`.
- rk  out  128  round key; word 4r is in `[127:96]`, word 4r+3 is in `[31:0]`.
- rk_round  out  4  index r of the round key on `rk`.
- rk_last  out  1  `rk` is round key 0, the final transfer.

## Operation
- Word store: a register array w[0 .. 4*(NR+1)-1] of 32-bit words.
- State IDLE:
  - key_ready = 1.
  - On key_valid && key_ready: w[j] = key word j for j < NK, i = NK, go to EXPAND.
- State EXPAND, one word per clock, computed from w[i-1] and w[i-NK]:
  - temp = w[i-1].
  - If i % NK == 0: temp = SubWord(RotWord(temp)) ^ Rcon(i/NK).
  - Else if NK > 6 and i % NK == 4: temp = SubWord(temp).
  - Write w[i] = w[i-NK] ^ temp, then i = i + 1.
  - On the edge that writes w[4*(NR+1)-1]: r = NR, go to STREAM.
- Word-level helpers:
  - RotWord rotates left by one byte: {x[23:0], x[31:24]}.
  - Rcon(k) = {rc_k, 24'h0}, with rc_k = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- State STREAM:
  - rk_valid = 1, rk = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, rk_round = r, rk_last = (r == 0).
  - On rk_valid && rk_ready: if r == 0, go to IDLE; else r = r - 1.
- Outside STREAM: rk = 0, rk_round = 0, rk_last = 0, rk_valid = 0.
- key_ready = 0 in EXPAND and STREAM. A key_valid pulse offered then is ignored and is not queued.
- rst asserted in any state, including mid-EXPAND and mid-STREAM:
  - State goes to IDLE immediately; i and r are cleared.
  - The contents of w are don't-care.
  - The stream is abandoned; there is no partial resume.
- Illegal NK/NR pairs cause an elaboration-time `$error`.

## Timing
- Values during reset: key_ready = 1, rk_valid = 0, rk = 0, rk_round = 0, rk_last = 0.
- All outputs are decoded from registered state and the word store. There is no combinational path from any input to any output.
- Latency from the key-accept edge to rk_valid first high is 4*(NR+1) - NK clocks: 40, 46 or 52 for AES-128, AES-192 and AES-256.
- Throughput in STREAM is one round key per clock while rk_ready = 1.
- While rk_valid && !rk_ready, rk, rk_round and rk_last hold stable.
- A new key is accepted at the earliest on the clock after the rk_last handshake, since key_ready rises once the state is back in IDLE.
- A full key cycle takes 1 accept clock, the expansion latency, then NR+1 transfers.

## Structure
- Shared package `aes_pkg` holds:
  - the `sbox` function (256-entry case), `rot_word`, `sub_word`, and `rcon` indexed 1 to 10;
  - state enum `ks_state_t` with values IDLE, EXPAND, STREAM;
  - localparam `AES_RK_W = 128`.
- The forward key expansion reuses the same package entries.
- Sub-module `aes_sub_word`: combinational, four S-box lookups on one 32-bit word. It is instantiated once and shared by both SubWord cases.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready held 1:
  - rk_valid rises 40 clocks after accept;
  - the first rk is d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_round = 10;
  - the 11th rk equals the key, with rk_round = 0 and rk_last = 1;
  - key_ready returns 1 on the next clock.
- AES-256 (NK=8, NR=14), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - latency is 52 clocks;
  - the first rk is fe4890d1e6188d0b046df344706c631e;
  - the final rk equals key[255:128].
- AES-192 (NK=6, NR=12), FIPS-197 A.2 key:
  - latency is 46 clocks;
  - all 13 round keys match A.2 in reverse order.
- Backpressure: hold rk_ready = 0 for 5 clocks at round 7, then toggle it 1/0 randomly.
  - rk and rk_round stay stable while stalled.
  - No round key is skipped or duplicated.
- Busy key offer: assert key_valid with a different key during EXPAND and during STREAM.
  - key_ready stays 0.
  - The output sequence belongs to the first key only.
- Reset mid-operation: assert rst at expansion word 20, then again at the round-4 transfer.
  - Outputs take their reset values immediately.
  - key_ready = 1.
  - A fresh key then produces correct output from round NR.
